// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
//   Stage 1 registers the operand bundle. Stage 2 registers the result and the
//   status flags, which are computed combinationally from stage 1.
//   A saturating counter tracks completed output transfers.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        operand bundle handshake
//   a, b, opcode, signed_cmp operand bundle
//   out_valid/out_ready      result bundle handshake
//   result, flag_c/v/z/n     result bundle
//   op_count                 completed-result count, saturating
module alu_pipe #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  input  logic               signed_cmp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               flag_c,
  output logic               flag_v,
  output logic               flag_z,
  output logic               flag_n,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_GT  = 3'b010,
    OP_LT  = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_EQ  = 3'b111
  } op_t;

  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_a;
  logic [WIDTH-1:0]   r_s1_b;
  logic [2:0]         r_s1_op;
  logic               r_s1_sc;

  logic               r_s2_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_c;
  logic               r_v;
  logic               r_z;
  logic               r_n;
  logic [COUNT_W-1:0] r_count;

  logic               w_s2_load;
  logic               w_s1_adv;
  logic               w_in_xfer;
  logic               w_out_xfer;

  logic               w_is_sub;
  logic [WIDTH-1:0]   w_b_eff;
  logic [WIDTH:0]     w_sum;
  logic               w_gt;
  logic               w_lt;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;

  // Handshake: in_ready depends only on out_ready and the valid bits.
  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_load;
  assign in_ready   = !r_s1_valid || w_s1_adv;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_s2_valid && out_ready;

  always_comb begin
    w_is_sub = (op_t'(r_s1_op) == OP_SUB);
    // SUB is a + ~b + 1, so the carry out reads as "no borrow".
    w_b_eff  = w_is_sub ? ~r_s1_b : r_s1_b;
    w_sum    = {1'b0, r_s1_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
    w_gt     = r_s1_sc ? ($signed(r_s1_a) > $signed(r_s1_b)) : (r_s1_a > r_s1_b);
    w_lt     = r_s1_sc ? ($signed(r_s1_a) < $signed(r_s1_b)) : (r_s1_a < r_s1_b);
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (op_t'(r_s1_op))
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_GT:   w_res = {{(WIDTH-1){1'b0}}, w_gt};
      OP_LT:   w_res = {{(WIDTH-1){1'b0}}, w_lt};
      OP_AND:  w_res = r_s1_a & r_s1_b;
      OP_OR:   w_res = r_s1_a | r_s1_b;
      OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (r_s1_a == r_s1_b)};
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s1_sc    <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= a;
      r_s1_b     <= b;
      r_s1_op    <= opcode;
      r_s1_sc    <= signed_cmp;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Result and flags only change when a new bundle lands, so they hold both
  // under backpressure and after the output drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_c        <= 1'b0;
      r_v        <= 1'b0;
      r_z        <= 1'b0;
      r_n        <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
        r_c      <= w_c;
        r_v      <= w_v;
        r_z      <= (w_res == '0);
        r_n      <= w_res[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_out_xfer && (r_count != {COUNT_W{1'b1}})) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign op_count  = r_count;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: bench for alu_pipe. A 32-bit instance is driven cycle by cycle
// against a transaction queue model; an 8-bit instance with a 2-bit counter
// covers narrow-width overflow and counter saturation.
module tb_alu_pipe;

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  typedef struct {
    exp_t e;
    int   stamp;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, signed_cmp;
  logic [31:0] a, b, result;
  logic [2:0]  opcode;
  logic        flag_c, flag_v, flag_z, flag_n;
  logic [15:0] op_count;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, signed_cmp8;
  logic [7:0]  a8, b8, result8;
  logic [2:0]  opcode8;
  logic        flag_c8, flag_v8, flag_z8, flag_n8;
  logic [1:0]  op_count8;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] mcount = '0;
  ent_t        q[$];
  logic        acc;
  int          accepted;
  exp_t        e8;

  alu_pipe #(.WIDTH(32), .COUNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .signed_cmp(signed_cmp),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .op_count(op_count)
  );

  alu_pipe #(.WIDTH(8), .COUNT_W(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .opcode(opcode8), .signed_cmp(signed_cmp8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .flag_c(flag_c8), .flag_v(flag_v8), .flag_z(flag_z8), .flag_n(flag_n8),
    .op_count(op_count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference from plain integer arithmetic on w-bit operands.
  function automatic exp_t ref_op(input int w, input longint unsigned ua, input longint unsigned ub,
                                  input logic [2:0] op, input logic sc);
    exp_t e;
    longint unsigned m, r;
    longint sa, sb, sr, hi;
    m  = 64'd1 << w;
    hi = longint'(m >> 1);
    sa = (ua >= (m >> 1)) ? longint'(ua) - longint'(m) : longint'(ua);
    sb = (ub >= (m >> 1)) ? longint'(ub) - longint'(m) : longint'(ub);
    sr = 0;
    r  = 0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      3'd0: begin
        r = (ua + ub) % m;
        e.c = ((ua + ub) >= m);
        sr = sa + sb;
        e.v = (sr >= hi) || (sr < -hi);
      end
      3'd1: begin
        r = (ua + m - ub) % m;
        e.c = (ua >= ub);
        sr = sa - sb;
        e.v = (sr >= hi) || (sr < -hi);
      end
      3'd2:    r = (sc ? (sa > sb) : (ua > ub)) ? 1 : 0;
      3'd3:    r = (sc ? (sa < sb) : (ua < ub)) ? 1 : 0;
      3'd4:    r = ua & ub;
      3'd5:    r = ua | ub;
      3'd6:    r = ua ^ ub;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    e.res = r;
    e.z = (r == 0);
    e.n = (r >= (m >> 1));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // One cycle on the 32-bit instance: drive, check against the model, update
  // the model for the coming edge, then advance to 1 ns after that edge.
  task automatic step(input logic iv, input logic [31:0] ta, input logic [31:0] tbv,
                      input logic [2:0] top, input logic tsc, input logic ordy, output logic acc_o);
    logic exp_ir, exp_ov;
    ent_t ent;
    in_valid = iv; a = ta; b = tbv; opcode = top; signed_cmp = tsc; out_ready = ordy;
    #1;
    exp_ir = (q.size() < 2) || ordy;
    exp_ov = (q.size() > 0) && (q[0].stamp + 2 <= cyc);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov && out_valid) begin
      chk("result", result, q[0].e.res);
      chk("flag_c", flag_c, q[0].e.c);
      chk("flag_v", flag_v, q[0].e.v);
      chk("flag_z", flag_z, q[0].e.z);
      chk("flag_n", flag_n, q[0].e.n);
    end
    chk("op_count", op_count, mcount);
    if (exp_ov && ordy) begin
      q.delete(0);
      if (mcount != 16'hFFFF) mcount++;
    end
    acc_o = iv && exp_ir;
    if (acc_o) begin
      ent.e = ref_op(32, ta, tbv, top, tsc);
      ent.stamp = cyc;
      q.push_back(ent);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic [2:0] top, input logic tsc);
    logic dummy;
    step(1'b1, ta, tbv, top, tsc, 1'b1, dummy);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, dummy);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, dummy);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; opcode = '0; signed_cmp = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; opcode8 = '0; signed_cmp8 = 1'b0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_op_count", op_count, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_c, flag_v, flag_z, flag_n}, 0);
    rst_n = 1'b1;

    // ADD wrap to zero
    run_op(32'hFFFF_FFFF, 32'h1, 3'd0, 1'b0);
    chk("tp1_op_count", op_count, 1);
    // SUB overflow and borrow
    run_op(32'h8000_0000, 32'h1, 3'd1, 1'b0);
    run_op(32'h0000_0000, 32'h1, 3'd1, 1'b0);
    chk("tp2_borrow_result", result, 32'hFFFF_FFFF);
    chk("tp2_borrow_c", flag_c, 0);
    // compares, signed and unsigned
    run_op(32'hFFFF_FFFF, 32'h1, 3'd2, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h1, 3'd2, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h1, 3'd3, 1'b1);
    chk("tp3_lt_signed", result, 1);
    run_op(32'h1234, 32'h1234, 3'd7, 1'b0);
    run_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4, 1'b0);
    run_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd5, 1'b0);
    run_op(32'hF0F0_F0F0, 32'hF0F0_F0F0, 3'd6, 1'b0);

    // six back-to-back ops with a 4-cycle stall mid-stream
    accepted = 0;
    for (int k = 0; k < 40 && (accepted < 6 || q.size() > 0); k++) begin
      step(accepted < 6, rnd_val(), rnd_val(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           !(k >= 2 && k < 6), acc);
      if (acc) accepted++;
    end
    chk("stream_accepted", accepted, 6);
    chk("stream_drained", q.size(), 0);
    chk("stream_op_count", op_count, mcount);

    // reset with two bundles in flight
    step(1'b1, 32'h5, 32'h6, 3'd0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h7, 32'h8, 3'd1, 1'b0, 1'b0, acc);
    chk("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    mcount = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(32'h1111_1111, 32'h2222_2222, 3'd0, 1'b0);
    chk("post_rst_op_count", op_count, 1);

    // random traffic with random backpressure
    for (int k = 0; k < 250; k++) begin
      step($urandom_range(0, 3) != 0, rnd_val(), rnd_val(), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
    end
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, acc);
    end
    chk("rand_drained", q.size(), 0);

    // narrow instance: overflow flags and counter saturation
    for (int k = 1; k <= 5; k++) begin
      in_valid8   = 1'b1;
      a8          = (k == 1) ? 8'h7F : 8'($urandom);
      b8          = (k == 1) ? 8'h01 : 8'($urandom);
      opcode8     = (k == 1) ? 3'd0 : 3'($urandom_range(0, 7));
      signed_cmp8 = 1'($urandom_range(0, 1));
      e8 = ref_op(8, a8, b8, opcode8, signed_cmp8);
      #1;
      chk("w8_in_ready", in_ready8, 1);
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      chk("w8_not_yet", out_valid8, 0);
      @(posedge clk);
      #1;
      chk("w8_out_valid", out_valid8, 1);
      chk("w8_result", result8, e8.res);
      chk("w8_flags", {flag_c8, flag_v8, flag_z8, flag_n8}, {e8.c, e8.v, e8.z, e8.n});
      if (k == 1) begin
        chk("w8_add_result", result8, 8'h80);
        chk("w8_add_vn", {flag_v8, flag_n8}, 2'b11);
      end
      @(posedge clk);
      #1;
      chk("w8_op_count", op_count8, (k < 3) ? k : 3);
      chk("w8_idle", out_valid8, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor of the team's 32-bit add/sub/compare ALU.
- Generalised data width; full 8-opcode set; signed/unsigned compare mode; status flags; valid/ready handshakes on input and output.
- Includes a saturating completed-operation counter.
- Sits between the operand-issue logic and the writeback arbiter in the datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (≥2).
- COUNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block accepts the bundle this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- opcode  in  3  operation select.
- signed_cmp  in  1  1 = GT/LT compare as two's complement; 0 = unsigned.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  operation result.
- flag_c  out  1  carry out; for SUB, 1 means no borrow.
- flag_v  out  1  signed overflow.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].
- op_count  out  COUNT_W  completed-result count, saturating.

Behaviour:
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a+~b+1.
  - 010 GT: zero-extended (a>b).
  - 011 LT: zero-extended (a<b).
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 EQ: zero-extended (a==b).
- Arithmetic is modulo 2^WIDTH.
- flag_c: the (WIDTH+1)th sum bit for ADD/SUB; 0 for all other opcodes.
- flag_v:
  - ADD: a[MSB]==b[MSB] and result[MSB]!=a[MSB].
  - SUB: a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
  - 0 for all other opcodes.
- flag_z and flag_n are computed for every opcode.
- signed_cmp affects only GT and LT.
- Pipeline stages:
  - Stage 1 (s1) registers a, b, opcode, signed_cmp.
  - Stage 2 (s2) registers result and flags, computed combinationally from s1.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Advance and ready rules:
  - s2 may load when !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid and s2 may load.
  - in_ready = !s1_valid || (s1 advances this cycle).
  - in_ready is combinational from out_ready and the valid state; there is no combinational path from in_valid.
- Latency: a transfer accepted in cycle t gives out_valid in cycle t+2 when there is no backpressure.
- Throughput: 1 operation per cycle.
- Backpressure:
  - While out_valid && !out_ready, result, flags and out_valid hold stable.
  - s1 holds when s2 cannot load.
  - At most 2 bundles are in flight; none are dropped or duplicated.
- Simultaneous events: output transfer, s1→s2 advance and input acceptance may all occur in one cycle.
- op_count increments by 1 on each output transfer and saturates at 2^COUNT_W−1.
- Reset:
  - rst_n low asynchronously clears s1_valid, s2_valid, result, all flags and op_count to 0.
  - in_ready reads 1 immediately after reset.
  - In-flight bundles are discarded when reset asserts mid-operation.
  - The first accepted bundle after reset release follows normal 2-cycle latency.
- Data inputs are don't-care when in_valid=0. Outputs other than out_valid are don't-care-stable when out_valid=0; the implementation holds the last value.

Test Plan:
1. Reset then ADD a=0xFFFFFFFF, b=1, out_ready=1 → out_valid 2 cycles after accept, result=0, C=1, Z=1, V=0, N=0, op_count=1.
2. SUB a=0x80000000, b=1 → result=0x7FFFFFFF, V=1, C=1, N=0. SUB a=0, b=1 → result=0xFFFFFFFF, C=0, N=1.
3. GT a=0xFFFFFFFF, b=1: signed_cmp=0 → result=1; signed_cmp=1 → result=0. LT with the same operands: signed_cmp=1 → 1. EQ a=b=0x1234 → 1.
4. Stream 6 back-to-back ops with out_ready held low for 4 cycles mid-stream → in_ready drops after 2 bundles in flight, outputs are stable while stalled, all 6 results arrive in order, op_count=6.
5. Assert rst_n low with 2 bundles in flight → out_valid=0 and op_count=0 immediately (asynchronously). The next op after release emerges 2 cycles after accept.
6. COUNT_W=2, 5 completed ops → op_count reads 1, 2, 3, 3, 3 (saturates). WIDTH=8 ADD 0x7F+0x01 → 0x80, V=1, N=1.
